flaf_err_mac: RTL and testbench

- Output/error stage of the functional-link adaptive filter; the counterpart of the per-tap weight-update cells.
- Reads the current weight vector and the expanded input vector, then serially computes the filter output y = sum(w[i]*x[i]).
- Forms the error e = d - y and produces the scaled error mu_error = mu*e that feeds every weight-update cell.
- Uses one shared multiplier, time-multiplexed over MAC and mu-scaling. Start/busy/done handshake.

---
 rtl/flaf_err_mac.sv | 124 ++++++++++++
 tb/tb_flaf_err_mac.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/flaf_err_mac.sv
// rtl/flaf_err_mac.sv - adaptive filter output/error stage with one shared multiplier
module flaf_err_mac #(
    parameter int WIDTH = 16,
    parameter int QP    = 12,
    parameter int TAPS  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [TAPS*WIDTH-1:0]   w_vec,
    input  logic [TAPS*WIDTH-1:0]   x_vec,
    input  logic [WIDTH-1:0]        d_n,
    input  logic [WIDTH-1:0]        mu,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        y_out,
    output logic [WIDTH-1:0]        error,
    output logic [WIDTH-1:0]        mu_error
);
    localparam int IW = $clog2(TAPS);
    localparam int AW = 2*WIDTH + IW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;
    localparam logic [1:0] S_MUL  = 2'd3;

    localparam logic signed [AW-1:0]      HALF_A = AW'(1) << (QP-1);
    localparam logic signed [2*WIDTH-1:0] HALF_P = (2*WIDTH)'(1) << (QP-1);
    localparam logic [WIDTH-1:0]          S_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]          S_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]               state;
    logic [IW-1:0]            idx;
    logic signed [AW-1:0]     acc;
    logic [TAPS*WIDTH-1:0]    w_r;
    logic [TAPS*WIDTH-1:0]    x_r;
    logic [WIDTH-1:0]         d_r;
    logic [WIDTH-1:0]         mu_r;

    logic signed [WIDTH-1:0]   op_a;
    logic signed [WIDTH-1:0]   op_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      y_full;
    logic [WIDTH-1:0]          y_sat;
    logic signed [WIDTH:0]     err_wide;
    logic [WIDTH-1:0]          err_sat;

    assign busy = (state != S_IDLE);

    // Shared multiplier operands: current tap during MAC, mu*error otherwise
    always_comb begin
        op_a = mu_r;
        op_b = error;
        if (state == S_MAC) begin
            op_a = w_r[idx*WIDTH +: WIDTH];
            op_b = x_r[idx*WIDTH +: WIDTH];
        end
    end

    assign prod = op_a * op_b;

    // Round half-up and saturate the accumulator, then form the saturated error from it
    always_comb begin
        y_full = (acc + HALF_A) >>> QP;
        if (y_full[AW-1:WIDTH-1] == {(AW-WIDTH+1){y_full[WIDTH-1]}})
            y_sat = y_full[WIDTH-1:0];
        else
            y_sat = y_full[AW-1] ? S_MIN : S_MAX;
        err_wide = {d_r[WIDTH-1], d_r} - {y_sat[WIDTH-1], y_sat};
        if (err_wide[WIDTH] != err_wide[WIDTH-1])
            err_sat = err_wide[WIDTH] ? S_MIN : S_MAX;
        else
            err_sat = err_wide[WIDTH-1:0];
    end

    // Sequencer: capture, serial MAC, error formation, mu scaling
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            acc      <= '0;
            w_r      <= '0;
            x_r      <= '0;
            d_r      <= '0;
            mu_r     <= '0;
            done     <= 1'b0;
            y_out    <= '0;
            error    <= '0;
            mu_error <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w_r   <= w_vec;
                        x_r   <= x_vec;
                        d_r   <= d_n;
                        mu_r  <= mu;
                        acc   <= '0;
                        idx   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc + {{IW{prod[2*WIDTH-1]}}, prod};
                    idx <= idx + 1'b1;
                    if (idx == IW'(TAPS-1))
                        state <= S_ERR;
                end
                S_ERR: begin
                    y_out <= y_sat;
                    error <= err_sat;
                    state <= S_MUL;
                end
                default: begin
                    mu_error <= WIDTH'((prod + HALF_P) >>> QP);
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flaf_err_mac.sv
// tb/tb_flaf_err_mac.sv - directed self-checking bench for flaf_err_mac
module tb_flaf_err_mac;
    localparam int WIDTH = 16;
    localparam int TAPS  = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    logic [TAPS*WIDTH-1:0] w_vec = '0;
    logic [TAPS*WIDTH-1:0] x_vec = '0;
    logic [WIDTH-1:0]      d_n = '0;
    logic [WIDTH-1:0]      mu = '0;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      y_out;
    logic [WIDTH-1:0]      error;
    logic [WIDTH-1:0]      mu_error;

    int checks = 0;
    int errors = 0;

    flaf_err_mac #(.WIDTH(WIDTH), .QP(12), .TAPS(TAPS)) dut (
        .clk(clk), .reset(reset), .start(start), .w_vec(w_vec), .x_vec(x_vec),
        .d_n(d_n), .mu(mu), .busy(busy), .done(done), .y_out(y_out),
        .error(error), .mu_error(mu_error)
    );

    always #5 clk = ~clk;

    task automatic set_all(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] x);
        for (int i = 0; i < TAPS; i++) begin
            w_vec[i*WIDTH +: WIDTH] = w;
            x_vec[i*WIDTH +: WIDTH] = x;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Edges after the start edge until done is seen (-1 on timeout); busy cycles counted on the way
    task automatic wait_done(output int n, output int busy_cnt);
        n = -1;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                n = k;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0h expected 0", done); end
        checks++; if ({y_out, error, mu_error} !== 48'h0) begin errors++; $display("FAIL reset_outputs: got %0h expected 0", {y_out, error, mu_error}); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_weights();
        int n, b;
        set_all(16'd0, 16'd1234);
        d_n = 16'd2048; mu = 16'd409;
        do_start();
        wait_done(n, b);
        checks++; if (n !== 10) begin errors++; $display("FAIL zero_latency: got %0d expected 10", n); end
        checks++; if (y_out !== 16'd0) begin errors++; $display("FAIL zero_y: got %0h expected 0", y_out); end
        checks++; if (error !== 16'd2048) begin errors++; $display("FAIL zero_err: got %0d expected 2048", error); end
        checks++; if (mu_error !== 16'd205) begin errors++; $display("FAIL zero_muerr: got %0d expected 205", mu_error); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %0h expected 0", done); end
    endtask

    task automatic test_unity();
        int n, b;
        set_all(16'd4096, 16'd512);
        d_n = 16'd4096; mu = 16'd4096;
        do_start();
        wait_done(n, b);
        checks++; if (n !== 10) begin errors++; $display("FAIL unity_latency: got %0d expected 10", n); end
        checks++; if (b !== 10) begin errors++; $display("FAIL unity_busy: got %0d expected 10", b); end
        checks++; if (y_out !== 16'd4096) begin errors++; $display("FAIL unity_y: got %0d expected 4096", y_out); end
        checks++; if (error !== 16'd0) begin errors++; $display("FAIL unity_err: got %0d expected 0", error); end
        checks++; if (mu_error !== 16'd0) begin errors++; $display("FAIL unity_muerr: got %0d expected 0", mu_error); end
    endtask

    task automatic test_saturation();
        int n, b;
        set_all(16'h7FFF, 16'h7FFF);
        d_n = 16'h8000; mu = 16'd4096;
        do_start();
        wait_done(n, b);
        checks++; if (y_out !== 16'h7FFF) begin errors++; $display("FAIL sat_y: got %0h expected 7fff", y_out); end
        checks++; if (error !== 16'h8000) begin errors++; $display("FAIL sat_err: got %0h expected 8000", error); end
        checks++; if (mu_error !== 16'h8000) begin errors++; $display("FAIL sat_muerr: got %0h expected 8000", mu_error); end
    endtask

    task automatic test_rounding();
        int n, b;
        logic [WIDTH-1:0] xs [3] = '{16'hF800, 16'hF7FF, 16'h0800};
        logic [WIDTH-1:0] ys [3] = '{16'h0000, 16'hFFFF, 16'h0001};
        for (int t = 0; t < 3; t++) begin
            set_all(16'd0, 16'd0);
            w_vec[0 +: WIDTH] = 16'd1;
            x_vec[0 +: WIDTH] = xs[t];
            d_n = 16'd0; mu = 16'd100;
            do_start();
            wait_done(n, b);
            checks++; if (y_out !== ys[t]) begin errors++; $display("FAIL round_y[%0d]: got %0h expected %0h", t, y_out, ys[t]); end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        int first = -1;
        set_all(16'd4096, 16'd512);
        d_n = 16'd4096; mu = 16'd4096;
        do_start();
        for (int k = 1; k <= 25; k++) begin
            start = (k == 3 || k == 5);
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                dones++;
                if (first < 0) first = k;
            end
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_count: got %0d expected 1", dones); end
        checks++; if (first !== 10) begin errors++; $display("FAIL ignore_latency: got %0d expected 10", first); end
    endtask

    task automatic test_back_to_back();
        int d0 = -1;
        int d1 = -1;
        set_all(16'd4096, 16'd512);
        d_n = 16'd4096; mu = 16'd4096;
        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 11) start = 1'b0;
            if (done) begin
                if (d0 < 0) d0 = k;
                else if (d1 < 0) d1 = k;
            end
        end
        checks++; if (d0 !== 10) begin errors++; $display("FAIL b2b_first: got %0d expected 10", d0); end
        checks++; if (d1 !== 21) begin errors++; $display("FAIL b2b_second: got %0d expected 21", d1); end
        checks++; if (y_out !== 16'd4096) begin errors++; $display("FAIL b2b_y: got %0d expected 4096", y_out); end
    endtask

    task automatic test_input_change();
        int n, b;
        set_all(16'd4096, 16'd512);
        d_n = 16'd4096; mu = 16'd4096;
        do_start();
        set_all(16'h7FFF, 16'h7FFF);
        d_n = 16'h8000; mu = 16'd1;
        wait_done(n, b);
        checks++; if (y_out !== 16'd4096) begin errors++; $display("FAIL hold_y: got %0d expected 4096", y_out); end
        checks++; if (error !== 16'd0) begin errors++; $display("FAIL hold_err: got %0d expected 0", error); end
    endtask

    task automatic test_async_reset();
        int n, b;
        set_all(16'd0, 16'd1234);
        d_n = 16'd2048; mu = 16'd409;
        do_start();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %0h expected 0", busy); end
        checks++; if ({done, y_out, error, mu_error} !== 49'h0) begin errors++; $display("FAIL areset_outputs: got %0h expected 0", {done, y_out, error, mu_error}); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_start();
        wait_done(n, b);
        checks++; if (n !== 10) begin errors++; $display("FAIL areset_latency: got %0d expected 10", n); end
        checks++; if ({y_out, error, mu_error} !== {16'd0, 16'd2048, 16'd205}) begin errors++; $display("FAIL areset_results: got %0h expected %0h", {y_out, error, mu_error}, {16'd0, 16'd2048, 16'd205}); end
    endtask

    initial begin
        test_reset();
        test_zero_weights();
        test_unity();
        test_saturation();
        test_rounding();
        test_ignore_start();
        test_back_to_back();
        test_input_change();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
